multicycle_control_32: RTL and testbench

Multi-cycle control sequencer for the 32-bit MIPS datapath. It consumes the `opcode` field that `Datapath_32` exports. It produces that datapath's control inputs (`RegDst` … `ALUOp`) phase by phase, plus the fetch-side enables `IRWrite` and `PCWrite`. Memory phases stall on a `mem_ready` handshake. A retired-instruction counter supports bench scoreboarding.

---
 rtl/multicycle_control_32.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control_32.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_32.sv
// Multi-cycle control sequencer for the 32-bit MIPS datapath.
// Moore FSM: controls decode from the state register. IRWrite, PCWrite and
// instr_done are additionally qualified by the mem_ready handshake.
module multicycle_control_32 #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             RegDst,
    output logic             Jump,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic [1:0]       ALUOp,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StAluWb  = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q;

    // State, latched opcode and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            op_q    <= 6'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            if (instr_done) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic; opcode is captured only while in DECODE
    always_comb begin
        state_d    = StFetch;
        op_d       = op_q;
        illegal_op = 1'b0;
        unique case (state_q)
            StFetch:  state_d = mem_ready ? StDecode : StFetch;
            StDecode: begin
                op_d = opcode;
                case (opcode)
                    OpRtype:    state_d = StExec;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            // Latched opcode decides direction, not the live IR field
            StMemAdr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
            StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
            StMemWb:  state_d = StFetch;
            StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
            StExec:   state_d = StAluWb;
            StAluWb:  state_d = StFetch;
            StBranch: state_d = StFetch;
            StJump:   state_d = StFetch;
            StAddiEx: state_d = StAddiWb;
            StAddiWb: state_d = StFetch;
            default:  state_d = StFetch;
        endcase
    end

    // Moore control decode; unlisted outputs stay 0
    always_comb begin
        RegDst     = 1'b0;
        Jump       = 1'b0;
        Branch     = 1'b0;
        MemRead    = 1'b0;
        MemtoReg   = 1'b0;
        MemWrite   = 1'b0;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        ALUOp      = AluAdd;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                // Fetch-side enables must stay quiet while reset is held
                IRWrite = mem_ready & rst_n;
                PCWrite = mem_ready & rst_n;
            end
            StDecode: ;
            StMemAdr: ALUSrc = 1'b1;
            StMemRd: begin
                MemRead = 1'b1;
                ALUSrc  = 1'b1;
            end
            StMemWb: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                MemWrite   = 1'b1;
                ALUSrc     = 1'b1;
                instr_done = mem_ready;
            end
            StExec: begin
                RegDst = 1'b1;
                ALUOp  = AluFunct;
            end
            StAluWb: begin
                RegDst     = 1'b1;
                ALUOp      = AluFunct;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                Branch     = 1'b1;
                ALUOp      = AluSub;
                instr_done = 1'b1;
            end
            StJump: begin
                Jump       = 1'b1;
                instr_done = 1'b1;
            end
            StAddiEx: ALUSrc = 1'b1;
            StAddiWb: begin
                ALUSrc     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign state         = state_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_control_32.sv
// Bench for multicycle_control_32: instruction-level model expands each
// opcode into its expected phase list and checks every cycle.
module tb_multicycle_control_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]  ALUOp;
    logic        IRWrite, PCWrite, instr_done, illegal_op;
    logic [3:0]  state;
    logic [31:0] retired_count;

    logic        s_RegDst, s_Jump, s_Branch, s_MemRead, s_MemtoReg, s_MemWrite;
    logic        s_ALUSrc, s_RegWrite, s_IRWrite, s_PCWrite, s_instr_done, s_illegal_op;
    logic [1:0]  s_ALUOp;
    logic [3:0]  s_state;
    logic [2:0]  s_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] mcount;

    typedef struct packed {
        logic       reg_dst, jump, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
        logic [1:0] alu_op;
        logic       ir_write, pc_write, done;
    } ctrl_t;

    ctrl_t act;
    assign act = {RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite,
                  ALUOp, IRWrite, PCWrite, instr_done};

    always #5 clk = ~clk;

    multicycle_control_32 dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
        .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .ALUOp(ALUOp), .IRWrite(IRWrite), .PCWrite(PCWrite), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state), .retired_count(retired_count)
    );

    // Narrow-counter build sharing all stimulus, used for the wrap check
    multicycle_control_32 #(.CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .RegDst(s_RegDst), .Jump(s_Jump), .Branch(s_Branch), .MemRead(s_MemRead),
        .MemtoReg(s_MemtoReg), .MemWrite(s_MemWrite), .ALUSrc(s_ALUSrc),
        .RegWrite(s_RegWrite), .ALUOp(s_ALUOp), .IRWrite(s_IRWrite), .PCWrite(s_PCWrite),
        .instr_done(s_instr_done), .illegal_op(s_illegal_op), .state(s_state),
        .retired_count(s_count)
    );

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Per-phase control table of the sequencer
    function automatic ctrl_t exp_ctrl(input int s, input logic mr, input logic rn);
        ctrl_t c = '0;
        case (s)
            0:  begin c.mem_read = 1; c.ir_write = mr & rn; c.pc_write = mr & rn; end
            2:  c.alu_src = 1;
            3:  begin c.mem_read = 1; c.alu_src = 1; end
            4:  begin c.mem_to_reg = 1; c.reg_write = 1; c.done = 1; end
            5:  begin c.mem_write = 1; c.alu_src = 1; c.done = mr; end
            6:  begin c.reg_dst = 1; c.alu_op = 2'b10; end
            7:  begin c.reg_dst = 1; c.alu_op = 2'b10; c.reg_write = 1; c.done = 1; end
            8:  begin c.branch = 1; c.alu_op = 2'b01; c.done = 1; end
            9:  begin c.jump = 1; c.done = 1; end
            10: c.alu_src = 1;
            11: begin c.alu_src = 1; c.reg_write = 1; c.done = 1; end
            default: ;
        endcase
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, advance the model
    task automatic step(input int es, input logic mr, input logic [5:0] op);
        ctrl_t e;
        logic [2:0] c3;
        mem_ready = mr;
        opcode    = op;
        #4;
        e  = exp_ctrl(es, mr, 1'b1);
        c3 = mcount[2:0];
        check("state", 32'(state), es);
        check("ctrl", 32'(act), 32'(e));
        check("illegal_op", 32'(illegal_op), 32'(es == 1 && !is_legal(op)));
        check("retired_count", retired_count, mcount);
        check("state_w3", 32'(s_state), es);
        check("count_w3", 32'(s_count), 32'(c3));
        @(posedge clk);
        #1;
        if (e.done) mcount = mcount + 1;
    endtask

    // Expand one instruction into its phase list with given stall counts
    task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
        int  sq[$];
        bit  mq[$];
        for (int i = 0; i < sf; i++) begin sq.push_back(0); mq.push_back(0); end
        sq.push_back(0); mq.push_back(1);
        sq.push_back(1); mq.push_back(1'($urandom));
        case (op)
            6'b000000: begin sq.push_back(6); sq.push_back(7); mq.push_back(1'($urandom));
                             mq.push_back(1'($urandom)); end
            6'b100011: begin
                sq.push_back(2); mq.push_back(1'($urandom));
                for (int i = 0; i < sm; i++) begin sq.push_back(3); mq.push_back(0); end
                sq.push_back(3); mq.push_back(1);
                sq.push_back(4); mq.push_back(1'($urandom));
            end
            6'b101011: begin
                sq.push_back(2); mq.push_back(1'($urandom));
                for (int i = 0; i < sm; i++) begin sq.push_back(5); mq.push_back(0); end
                sq.push_back(5); mq.push_back(1);
            end
            6'b000100: begin sq.push_back(8); mq.push_back(1'($urandom)); end
            6'b000010: begin sq.push_back(9); mq.push_back(1'($urandom)); end
            6'b001000: begin sq.push_back(10); sq.push_back(11); mq.push_back(1'($urandom));
                             mq.push_back(1'($urandom)); end
            default: ;
        endcase
        foreach (sq[i]) step(sq[i], mq[i], op);
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
        mcount    = 0;
        rst_n     = 1'b0;
        opcode    = 6'd0;
        mem_ready = 1'b1;
        #2;
        check("reset_state", 32'(state), 0);
        check("reset_ctrl", 32'(act), 32'(exp_ctrl(0, 1'b1, 1'b0)));
        check("reset_count", retired_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(6'b000000, 0, 0);
        check("count_after_rtype", retired_count, 1);
        run_instr(6'b100011, 0, 2);
        run_instr(6'b101011, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);
        check("count_after_swbeqj", retired_count, 5);
        run_instr(6'b111111, 1, 0);
        check("count_after_illegal", retired_count, 5);

        // Asynchronous reset while sw stalls in MEMWR
        step(0, 1'b1, 6'b101011);
        step(1, 1'b1, 6'b101011);
        step(2, 1'b1, 6'b101011);
        mem_ready = 1'b0;
        #2;
        check("memwr_before_reset", 32'(state), 5);
        rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state), 0);
        check("async_reset_ctrl", 32'(act), 32'(exp_ctrl(0, 1'b0, 1'b0)));
        check("async_reset_count", retired_count, 0);
        mem_ready = 1'b1;
        #1;
        check("reset_gates_irwrite", 32'(act), 32'(exp_ctrl(0, 1'b1, 1'b0)));
        @(posedge clk);
        #1;
        check("reset_held_state", 32'(state), 0);
        rst_n  = 1'b1;
        mcount = 0;

        for (int i = 0; i < 8; i++) run_instr(6'b001000, 0, 0);
        check("wrap_w3", 32'(s_count), 0);
        check("count_after_addi", retired_count, 8);

        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so a stuck bench still ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
